// File: rtl/word_aligner_10b.sv
// word_aligner_10b: hunts K28.5 commas in a serial 8b/10b bit stream, confirms alignment, emits aligned 10b words.
// Optional feature macro ALIGN_STATS_EN adds o_Realign_Cnt (saturating count of LOCKED->HUNT transitions).
module word_aligner_10b #(
  parameter int         CONFIRM_N = 3,
  parameter int         LOSS_N    = 4,
  parameter logic [9:0] COMMA_P   = 10'b0011111010,
  parameter logic [9:0] COMMA_N   = 10'b1100000101
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Bit_Valid,
  input  logic       i_Bit,
  output logic [9:0] o_Word,
  output logic       o_Word_Valid,
  output logic       o_Is_Comma,
  output logic       o_Locked,
  output logic [1:0] o_State
`ifdef ALIGN_STATS_EN
  ,
  output logic [7:0] o_Realign_Cnt
`endif
);

  localparam int CW = $clog2(CONFIRM_N + 1);
  localparam int MW = $clog2(LOSS_N + 1);
  localparam logic [CW-1:0] CONFIRM_MAX = CW'(CONFIRM_N);
  localparam logic [MW-1:0] LOSS_MAX    = MW'(LOSS_N);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'b00,
    ST_SYNC   = 2'b01,
    ST_LOCKED = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [8:0]    sr_q, sr_d;
  logic [3:0]    ph_q, ph_d;
  logic [CW-1:0] confirm_q, confirm_d, confirm_inc;
  logic [MW-1:0] miss_q, miss_d, miss_inc;
  logic [9:0]    word_q, word_d;
  logic          word_valid_q, word_valid_d;
  logic          is_comma_q, is_comma_d;

  logic [9:0]    nxt;
  logic          comma;
  logic          boundary;
  logic          emit;

  // Candidate word formed by the bit being accepted this cycle.
  always_comb begin
    nxt         = {sr_q, i_Bit};
    comma       = (nxt == COMMA_P) || (nxt == COMMA_N);
    boundary    = (ph_q == 4'd9);
    confirm_inc = (confirm_q == CONFIRM_MAX) ? confirm_q : confirm_q + CW'(1);
    miss_inc    = (miss_q == LOSS_MAX) ? miss_q : miss_q + MW'(1);
  end

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    ph_d         = ph_q;
    confirm_d    = confirm_q;
    miss_d       = miss_q;
    word_d       = word_q;
    is_comma_d   = is_comma_q;
    word_valid_d = 1'b0;
    emit         = 1'b0;

    if (i_Bit_Valid) begin
      sr_d = nxt[8:0];
      ph_d = boundary ? 4'd0 : ph_q + 4'd1;

      unique case (state_q)
        ST_HUNT: begin
          if (comma) begin
            ph_d      = 4'd0;
            emit      = 1'b1;
            confirm_d = CW'(1);
            if (CONFIRM_N <= 1) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end else begin
              state_d = ST_SYNC;
            end
          end
        end

        ST_SYNC: begin
          emit = boundary;
          if (comma) begin
            if (boundary) begin
              confirm_d = confirm_inc;
              if (confirm_inc == CONFIRM_MAX) begin
                state_d = ST_LOCKED;
                miss_d  = '0;
              end
            end else begin
              // A comma off the current phase restarts confirmation on its own boundary.
              ph_d      = 4'd0;
              emit      = 1'b1;
              confirm_d = CW'(1);
            end
          end
        end

        ST_LOCKED: begin
          emit = boundary;
          if (comma) begin
            if (boundary) begin
              miss_d = '0;
            end else begin
              // Stray commas are tolerated; only repeated ones drop lock, and never realign.
              miss_d = miss_inc;
              if (miss_inc == LOSS_MAX) begin
                state_d = ST_HUNT;
              end
            end
          end
        end

        default: state_d = ST_HUNT;
      endcase

      if (emit) begin
        word_d       = nxt;
        word_valid_d = 1'b1;
        is_comma_d   = comma;
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q      <= ST_HUNT;
      sr_q         <= '0;
      ph_q         <= '0;
      confirm_q    <= '0;
      miss_q       <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      is_comma_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      ph_q         <= ph_d;
      confirm_q    <= confirm_d;
      miss_q       <= miss_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      is_comma_q   <= is_comma_d;
    end
  end

`ifdef ALIGN_STATS_EN
  logic [7:0] realign_q, realign_d;

  always_comb begin
    realign_d = realign_q;
    if ((state_q == ST_LOCKED) && (state_d == ST_HUNT) && (realign_q != 8'hFF)) begin
      realign_d = realign_q + 8'd1;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      realign_q <= '0;
    end else begin
      realign_q <= realign_d;
    end
  end

  assign o_Realign_Cnt = realign_q;
`endif

  assign o_Word       = word_q;
  assign o_Word_Valid = word_valid_q;
  assign o_Is_Comma   = is_comma_q;
  assign o_Locked     = (state_q == ST_LOCKED);
  assign o_State      = state_q;

endmodule
